// File: rtl/picnic_seq_pkg.sv
// Shared types and constants for the Picnic stage sequencer.
package picnic_seq_pkg;

  localparam int unsigned STAGE_IDX_W = 4;

  // Default role of each handshaked engine in the signing flow
  localparam int unsigned STG_TREE   = 0;
  localparam int unsigned STG_TAPES  = 1;
  localparam int unsigned STG_AUX    = 2;
  localparam int unsigned STG_COMMIT = 3;
  localparam int unsigned STG_HCH    = 4;
  localparam int unsigned STG_HCV    = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FINISH  = 3'd4,
    ST_HOLD    = 3'd5,
    ST_FAULT   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/picnic_stage_watchdog.sv
// Per-stage cycle counter; o_expire_c flags the last allowed cycle of a nonzero limit.
module picnic_stage_watchdog #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [TIMEOUT_W-1:0] i_limit,
  output logic                 o_expire_c
);

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

  assign o_expire_c = (i_limit != '0) && (r_count == i_limit - TIMEOUT_W'(1));

endmodule

// File: rtl/picnic_stage_sequencer.sv
// Runs the Picnic sub-engines in order for a programmable number of repetitions,
// with stage skipping, watchdog fault reporting and masked-key / digest capture.
module picnic_stage_sequencer
  import picnic_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned ROUNDS_W   = 8,
  parameter int unsigned TIMEOUT_W  = 16,
  parameter int unsigned KEY_W      = 128,
  parameter int unsigned DIGEST_W   = 256,
  parameter int unsigned MASK_STAGE = STG_AUX,
  parameter int unsigned CH_STAGE   = STG_HCH,
  parameter int unsigned CV_STAGE   = STG_HCV
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [ROUNDS_W-1:0]    i_num_rounds,
  input  logic [NUM_STAGES-1:0]  i_skip_mask,
  input  logic [TIMEOUT_W-1:0]   i_timeout_limit,
  output logic [NUM_STAGES-1:0]  o_stage_start,
  input  logic [NUM_STAGES-1:0]  i_stage_done,
  input  logic [KEY_W-1:0]       i_sk,
  input  logic [KEY_W-1:0]       i_mask,
  input  logic [DIGEST_W-1:0]    i_digest_ch,
  input  logic [DIGEST_W-1:0]    i_digest_cv,
  output logic [ROUNDS_W-1:0]    o_round_idx,
  output logic [STAGE_IDX_W-1:0] o_stage_idx,
  output logic [KEY_W-1:0]       o_masked_key,
  output logic [DIGEST_W-1:0]    o_ch,
  output logic [DIGEST_W-1:0]    o_cv,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [STAGE_IDX_W-1:0] o_err_stage
);

  seq_state_e             r_state;
  logic [ROUNDS_W-1:0]    r_num_rounds;
  logic [NUM_STAGES-1:0]  r_skip;
  logic [TIMEOUT_W-1:0]   r_timeout;
  logic [NUM_STAGES-1:0]  r_stage_start;
  logic [ROUNDS_W-1:0]    r_round_idx;
  logic [STAGE_IDX_W-1:0] r_stage_idx;
  logic [KEY_W-1:0]       r_masked_key;
  logic [DIGEST_W-1:0]    r_ch;
  logic [DIGEST_W-1:0]    r_cv;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic [STAGE_IDX_W-1:0] r_err_stage;

  logic [NUM_STAGES-1:0]  w_onehot;
  logic                   w_skip_cur;
  logic                   w_done_cur;
  logic                   w_wd_clr;
  logic                   w_wd_en;
  logic                   w_expire;

  // Decode the active stage once; avoids variable bit-selects of mismatched width
  assign w_onehot   = NUM_STAGES'(1) << r_stage_idx;
  assign w_skip_cur = |(r_skip & w_onehot);
  assign w_done_cur = |(i_stage_done & w_onehot);
  assign w_wd_clr   = (r_state == ST_LAUNCH) && !w_skip_cur;
  assign w_wd_en    = (r_state == ST_WAIT) && !w_done_cur && !w_expire;

  picnic_stage_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_wd_clr),
    .i_en       (w_wd_en),
    .i_limit    (r_timeout),
    .o_expire_c (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_num_rounds  <= '0;
      r_skip        <= '0;
      r_timeout     <= '0;
      r_stage_start <= '0;
      r_round_idx   <= '0;
      r_stage_idx   <= '0;
      r_masked_key  <= KEY_W'(1);
      r_ch          <= '0;
      r_cv          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_err_stage   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !r_done) begin
            r_num_rounds <= i_num_rounds;
            r_skip       <= i_skip_mask;
            r_timeout    <= i_timeout_limit;
            r_round_idx  <= '0;
            r_stage_idx  <= '0;
            r_error      <= 1'b0;
            r_err_stage  <= '0;
            r_busy       <= 1'b1;
            r_state      <= (i_num_rounds == '0) ? ST_FINISH : ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (!i_start) begin
            r_stage_start <= '0;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else if (w_skip_cur) begin
            r_state <= ST_ADVANCE;
          end else begin
            r_stage_start <= w_onehot;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_start) begin
            r_stage_start <= '0;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else if (w_done_cur) begin
            r_stage_start <= '0;
            if (r_stage_idx == STAGE_IDX_W'(MASK_STAGE)) r_masked_key <= i_sk ^ i_mask;
            if (r_stage_idx == STAGE_IDX_W'(CH_STAGE))   r_ch <= i_digest_ch;
            if (r_stage_idx == STAGE_IDX_W'(CV_STAGE))   r_cv <= i_digest_cv;
            r_state <= ST_ADVANCE;
          end else if (w_expire) begin
            // Fault is reported on the expiring edge itself
            r_stage_start <= '0;
            r_busy        <= 1'b0;
            r_error       <= 1'b1;
            r_err_stage   <= r_stage_idx;
            r_state       <= ST_FAULT;
          end
        end
        ST_ADVANCE: begin
          if (!i_start) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_stage_idx != STAGE_IDX_W'(NUM_STAGES - 1)) begin
            r_stage_idx <= r_stage_idx + STAGE_IDX_W'(1);
            r_state     <= ST_LAUNCH;
          end else if (r_round_idx == r_num_rounds - ROUNDS_W'(1)) begin
            r_state <= ST_FINISH;
          end else begin
            r_stage_idx <= '0;
            r_round_idx <= r_round_idx + ROUNDS_W'(1);
            r_state     <= ST_LAUNCH;
          end
        end
        ST_FINISH: begin
          r_busy <= 1'b0;
          if (!i_start) begin
            r_state <= ST_IDLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!i_start) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (!i_start) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stage_start = r_stage_start;
  assign o_round_idx   = r_round_idx;
  assign o_stage_idx   = r_stage_idx;
  assign o_masked_key  = r_masked_key;
  assign o_ch          = r_ch;
  assign o_cv          = r_cv;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_err_stage   = r_err_stage;

endmodule

// File: tb/tb_picnic_stage_sequencer.sv
// Directed bench for picnic_stage_sequencer: ordering, repetitions, skip,
// watchdog fault, abort, zero rounds and asynchronous reset.
module tb_picnic_stage_sequencer;

  localparam int unsigned NS  = 6;
  localparam int unsigned RW  = 8;
  localparam int unsigned TW  = 16;
  localparam int unsigned KW  = 128;
  localparam int unsigned DW  = 256;

  logic          clk;
  logic          reset;
  logic          start;
  logic [RW-1:0] num_rounds;
  logic [NS-1:0] skip_mask;
  logic [TW-1:0] timeout_limit;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done;
  logic [KW-1:0] sk;
  logic [KW-1:0] mask;
  logic [DW-1:0] digest_ch;
  logic [DW-1:0] digest_cv;
  logic [RW-1:0] round_idx;
  logic [3:0]    stage_idx;
  logic [KW-1:0] masked_key;
  logic [DW-1:0] ch;
  logic [DW-1:0] cv;
  logic          busy;
  logic          done;
  logic          error;
  logic [3:0]    err_stage;

  logic [NS-1:0] respond;
  logic [DW-1:0] ch_base;
  logic [DW-1:0] cv_base;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int launch_q[$];
  int launch_round_q[$];
  logic [NS-1:0] launched_or;
  logic [NS-1:0] prev_start;
  int multi_hot = 0;

  picnic_stage_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (start),
    .i_num_rounds    (num_rounds),
    .i_skip_mask     (skip_mask),
    .i_timeout_limit (timeout_limit),
    .o_stage_start   (stage_start),
    .i_stage_done    (stage_done),
    .i_sk            (sk),
    .i_mask          (mask),
    .i_digest_ch     (digest_ch),
    .i_digest_cv     (digest_cv),
    .o_round_idx     (round_idx),
    .o_stage_idx     (stage_idx),
    .o_masked_key    (masked_key),
    .o_ch            (ch),
    .o_cv            (cv),
    .o_busy          (busy),
    .o_done          (done),
    .o_error         (error),
    .o_err_stage     (err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engines answer in the same cycle they are started, unless masked off
  assign stage_done = stage_start & respond;
  always_comb digest_ch = ch_base ^ DW'(round_idx);
  always_comb digest_cv = cv_base;

  // Launch log: record each rising stage_start vector and its round
  always @(negedge clk) begin
    if ($countones(stage_start) > 1) multi_hot++;
    if (stage_start != '0 && stage_start != prev_start) begin
      for (int i = 0; i < int'(NS); i++) begin
        if (stage_start[i]) launch_q.push_back(i);
      end
      launch_round_q.push_back(int'(round_idx));
      launched_or = launched_or | stage_start;
    end
    prev_start = stage_start;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    launch_q.delete();
    launch_round_q.delete();
    launched_or = '0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 200) begin
      tick(1);
      edges++;
      if (done) break;
    end
  endtask

  task automatic wait_start_bit(input int b, output int edges);
    edges = 0;
    while (edges < 200) begin
      tick(1);
      edges++;
      if (stage_start[b]) break;
    end
  endtask

  int edges;
  int cnt;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    num_rounds = RW'(1);
    skip_mask = '0;
    timeout_limit = '0;
    sk = KW'(1);
    mask = KW'(3);
    respond = '1;
    ch_base = {64'hC0FFEE00_11223344, 64'h55667788_99AABBCC, 64'h0, 64'hDEAD_BEEF_0000_1000};
    cv_base = {64'hFACE_0001, 64'h0, 64'hABCD_EF01_2345_6789, 64'h4242_4242};
    prev_start = '0;
    launched_or = '0;
    tick(2);

    check("rst_stage_start", 256'(stage_start), 256'(0));
    check("rst_round_idx",   256'(round_idx),   256'(0));
    check("rst_stage_idx",   256'(stage_idx),   256'(0));
    check("rst_masked_key",  256'(masked_key),  256'(1));
    check("rst_ch",          ch,                256'(0));
    check("rst_busy",        256'(busy),        256'(0));
    check("rst_done",        256'(done),        256'(0));
    check("rst_error",       256'(error),       256'(0));
    reset = 1'b1;
    tick(2);

    // Single round, every stage answers immediately
    clear_log();
    start = 1'b1;
    wait_done(edges);
    check("r1_done_edges", 256'(edges), 256'(20));
    check("r1_launches", 256'(launch_q.size()), 256'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < launch_q.size()) check("r1_order", 256'(launch_q[i]), 256'(i));
    end
    check("r1_masked_key", 256'(masked_key), 256'(2));
    check("r1_ch", ch, ch_base);
    check("r1_cv", cv, cv_base);
    check("r1_busy", 256'(busy), 256'(0));
    tick(3);
    check("r1_done_held", 256'(done), 256'(1));
    start = 1'b0;
    tick(1);
    check("r1_done_cleared", 256'(done), 256'(0));

    // Three rounds; ch captured from the last round's digest
    clear_log();
    num_rounds = RW'(3);
    sk = KW'(5);
    mask = KW'(12);
    start = 1'b1;
    wait_done(edges);
    check("r3_done_edges", 256'(edges), 256'(56));
    check("r3_launches", 256'(launch_q.size()), 256'(18));
    if (launch_round_q.size() == 18) begin
      check("r3_round_at_l6",  256'(launch_round_q[6]),  256'(1));
      check("r3_round_at_l17", 256'(launch_round_q[17]), 256'(2));
    end
    check("r3_ch", ch, ch_base ^ 256'(2));
    check("r3_masked_key", 256'(masked_key), 256'(9));
    start = 1'b0;
    tick(1);

    // Skip stage 1
    clear_log();
    num_rounds = RW'(1);
    skip_mask = 6'b000010;
    start = 1'b1;
    wait_done(edges);
    check("skip_done_edges", 256'(edges), 256'(19));
    check("skip_launched", 256'(launched_or), 256'(6'b111101));
    start = 1'b0;
    skip_mask = '0;
    tick(1);

    // Stage 3 never answers: watchdog fault
    clear_log();
    timeout_limit = TW'(5);
    respond = 6'b110111;
    start = 1'b1;
    wait_start_bit(3, edges);
    cnt = 0;
    while (cnt < 50) begin
      tick(1);
      cnt++;
      if (error) break;
    end
    check("to_fault_cycles", 256'(cnt), 256'(5));
    check("to_err_stage", 256'(err_stage), 256'(3));
    check("to_stage_start", 256'(stage_start), 256'(0));
    check("to_busy", 256'(busy), 256'(0));
    tick(4);
    check("to_done", 256'(done), 256'(0));
    start = 1'b0;
    tick(2);
    check("to_error_sticky", 256'(error), 256'(1));

    // Abort while stage 2 is waiting; captures keep their values
    timeout_limit = '0;
    respond = 6'b111011;
    sk = KW'(7);
    start = 1'b1;
    wait_start_bit(2, edges);
    check("ab_error_cleared", 256'(error), 256'(0));
    check("ab_busy_run", 256'(busy), 256'(1));
    start = 1'b0;
    tick(1);
    check("ab_stage_start", 256'(stage_start), 256'(0));
    check("ab_busy", 256'(busy), 256'(0));
    tick(3);
    check("ab_done", 256'(done), 256'(0));
    check("ab_masked_key", 256'(masked_key), 256'(9));
    respond = '1;

    // Zero repetitions
    clear_log();
    num_rounds = '0;
    start = 1'b1;
    wait_done(edges);
    check("z_done_edges", 256'(edges), 256'(2));
    check("z_launches", 256'(launch_q.size()), 256'(0));
    start = 1'b0;
    tick(1);

    // Asynchronous reset mid-run
    num_rounds = RW'(3);
    start = 1'b1;
    tick(10);
    check("rm_busy_before", 256'(busy), 256'(1));
    reset = 1'b0;
    #1;
    check("rm_masked_key", 256'(masked_key), 256'(1));
    check("rm_busy", 256'(busy), 256'(0));
    check("rm_stage_start", 256'(stage_start), 256'(0));
    check("rm_stage_idx", 256'(stage_idx), 256'(0));
    check("rm_ch", ch, 256'(0));
    check("rm_cv", cv, 256'(0));
    start = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);

    check("one_hot_start", 256'(multi_hot), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/picnic_stage_sequencer.md
Name: picnic_stage_sequencer

Overview:
- Parametrised control sequencer for the Picnic-on-SM4 signing flow.
- Runs NUM_STAGES sub-engines (seed tree, tapes, aux, commitment, MPC, Ch/Cv hashes) in fixed order over a programmable number of repetitions.
- Each sub-engine is driven by a start/done handshake. Supports per-run stage skipping and a per-stage watchdog timeout with fault reporting.
- Captures the masked key and the Ch/Cv digests at configurable stages. Sits between the top-level signer FSM and the stage engines.

Parameters:
- NUM_STAGES, 6, number of handshaked sub-engines (2..16)
- ROUNDS_W, 8, width of the repetition count
- TIMEOUT_W, 16, width of the watchdog limit and counter
- KEY_W, 128, key / mask width
- DIGEST_W, 256, hash digest width
- MASK_STAGE, 2, stage whose done captures masked_key
- CH_STAGE, 4, stage whose done captures ch
- CV_STAGE, 5, stage whose done captures cv

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level request; a run begins when start is high and done is low
- num_rounds  in  ROUNDS_W  repetitions per run; latched at run start
- skip_mask  in  NUM_STAGES  bit i=1 bypasses stage i; latched at run start
- timeout_limit  in  TIMEOUT_W  watchdog limit in cycles; 0 disables; latched at run start
- stage_start  out  NUM_STAGES  one-hot start to the active engine
- stage_done  in  NUM_STAGES  done from each engine; level or pulse
- sk  in  KEY_W  secret key
- mask  in  KEY_W  MPC input mask
- digest_ch  in  DIGEST_W  Ch hash result
- digest_cv  in  DIGEST_W  Cv hash result
- round_idx  out  ROUNDS_W  current repetition index
- stage_idx  out  4  current stage index
- masked_key  out  KEY_W  sk^mask
- ch  out  DIGEST_W  captured Ch
- cv  out  DIGEST_W  captured Cv
- busy  out  1  run in progress
- done  out  1  run completed
- error  out  1  watchdog fault
- err_stage  out  4  stage that timed out

Behaviour:
- Reset values: all outputs 0, except masked_key = 1 (legacy value). State is IDLE.
- States: IDLE, LAUNCH, WAIT, ADVANCE, FINISH, HOLD, FAULT.
- IDLE:
  - If start=1 and done=0: latch num_rounds, skip_mask and timeout_limit; clear round_idx, stage_idx, error and err_stage; set busy=1.
  - Go to FINISH if num_rounds==0, else go to LAUNCH.
- LAUNCH:
  - If skip[stage_idx]=1: go to ADVANCE.
  - Else: set stage_start[stage_idx]=1, clear the timer, go to WAIT.
- WAIT:
  - stage_done[stage_idx]=1 takes priority over timeout. On done: drop stage_start, perform captures, go to ADVANCE.
  - Else, if limit≠0 and timer==limit-1: go to FAULT.
  - Else: increment the timer.
  - stage_done bits of non-active stages are ignored.
- Captures, on done of the named stage in every round (last round wins):
  - MASK_STAGE: masked_key <= sk^mask.
  - CH_STAGE: ch <= digest_ch.
  - CV_STAGE: cv <= digest_cv.
- ADVANCE:
  - If stage_idx<NUM_STAGES-1: stage_idx++, go to LAUNCH.
  - Else, if round_idx==num_rounds-1: go to FINISH.
  - Else: stage_idx=0, round_idx++, go to LAUNCH.
- FINISH: done=1, busy=0, go to HOLD.
- HOLD: done stays high until start=0; then done=0 and go to IDLE. Restarting requires start to go low and then high again.
- FAULT:
  - error=1, err_stage=stage_idx, stage_start=0, busy=0.
  - Remains until start=0, then go to IDLE. error stays high until the next run starts.
- Abort: start=0 while busy:
  - Next edge: stage_start=0, busy=0, go to IDLE.
  - No done is raised. Captured outputs keep their values.
- Timing:
  - A non-skipped stage with same-cycle done costs 3 cycles (LAUNCH, WAIT, ADVANCE).
  - A skipped stage costs 2 cycles.
  - At most one stage_start bit is ever high.
- Asynchronous reset mid-run returns to the reset values immediately.

Decomposition:
- Shared package picnic_seq_pkg holds:
  - the state enum;
  - the STAGE_IDX_W=4 constant;
  - the default stage-role constants (STG_TREE=0 .. STG_HCV=5).
- Sub-module picnic_stage_watchdog: TIMEOUT_W counter with clear, enable, limit and expire outputs.

Test Plan:
- Default parameters, all engines assert done in the same cycle as start, num_rounds=1, sk=1, mask=3, timeout=0:
  - stage_start pulses 0..5 in order;
  - done rises 20 edges after start is first sampled;
  - masked_key=2; ch and cv equal the driven digests.
- num_rounds=3:
  - round_idx steps 0→1→2; 18 stage launches in total;
  - done after 56 edges;
  - ch holds the round-2 digest.
- skip_mask=6'b000010, num_rounds=1: stage 1 never started; done after 19 edges.
- timeout_limit=5, stage 3 never answers:
  - error=1 and err_stage=3 five cycles after stage_start[3] rises;
  - stage_start=0; done stays 0.
- Abort by dropping start during WAIT of stage 2: stage_start clears next edge; busy=0; no done.
- num_rounds=0: no stage_start at all; done high 2 edges after start.
- Reset asserted mid-run: all outputs return to reset values and masked_key=1 immediately.
